// File: rtl/admo_issue_stage_pkg.sv
// rtl/admo_issue_stage_pkg.sv - shared widths, ALU operator codes and operand-select encodings
package admo_issue_stage_pkg;

  localparam int ADMO_DATA_WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic SRC_A_RS1 = 1'b0;
  localparam logic SRC_A_PC  = 1'b1;
  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

endpackage

// File: rtl/admo_fwd_mux.sv
// rtl/admo_fwd_mux.sv - per-source MEM match, operand select and stall request
// Build option ADMO_FWD_EN: forward non-load MEM results; otherwise every MEM match stalls.
module admo_fwd_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic [REG_AW-1:0]     src_addr_i,
  input  logic [DATA_WIDTH-1:0] held_data_i,
  input  logic [REG_AW-1:0]     mem_rd_addr_i,
  input  logic                  mem_rd_we_i,
  input  logic                  mem_is_load_i,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  stall_o
);

  logic mem_hit;
  assign mem_hit = mem_rd_we_i && (src_addr_i != '0) && (src_addr_i == mem_rd_addr_i);

`ifdef ADMO_FWD_EN
  // A load's value is not known until WB, so only ALU results are forwarded.
  assign data_o  = (mem_hit && !mem_is_load_i) ? mem_rd_data_i : held_data_i;
  assign stall_o = mem_hit && mem_is_load_i;
`else
  logic unused_fwd;
  assign unused_fwd = mem_is_load_i ^ (^mem_rd_data_i);
  assign data_o     = held_data_i;
  assign stall_o    = mem_hit;
`endif

endmodule

// File: rtl/admo_issue_stage.sv
// rtl/admo_issue_stage.sv - ID/EX slot with WB snoop, MEM forwarding and load-use stall
// Build option ADMO_FWD_EN: enables combinational MEM forwarding in admo_fwd_mux.
module admo_issue_stage
  import admo_issue_stage_pkg::*;
#(
  parameter int DATA_WIDTH = ADMO_DATA_WIDTH,
  parameter int REG_AW     = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [DATA_WIDTH-1:0] id_pc_i,
  input  logic [DATA_WIDTH-1:0] id_rs1_data_i,
  input  logic [DATA_WIDTH-1:0] id_rs2_data_i,
  input  logic [DATA_WIDTH-1:0] id_imm_i,
  input  logic [REG_AW-1:0]     id_rs1_addr_i,
  input  logic [REG_AW-1:0]     id_rs2_addr_i,
  input  logic [REG_AW-1:0]     id_rd_addr_i,
  input  logic                  id_rd_we_i,
  input  logic [3:0]            id_alu_op_i,
  input  logic                  id_src_a_sel_i,
  input  logic                  id_src_b_sel_i,
  input  logic [REG_AW-1:0]     mem_rd_addr_i,
  input  logic                  mem_rd_we_i,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  input  logic                  mem_is_load_i,
  input  logic [REG_AW-1:0]     wb_rd_addr_i,
  input  logic                  wb_rd_we_i,
  input  logic [DATA_WIDTH-1:0] wb_rd_data_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [DATA_WIDTH-1:0] ex_operand_a_o,
  output logic [DATA_WIDTH-1:0] ex_operand_b_o,
  output logic [3:0]            ex_alu_op_o,
  output logic [REG_AW-1:0]     ex_rd_addr_o,
  output logic                  ex_rd_we_o,
  output logic [DATA_WIDTH-1:0] ex_store_data_o
);

  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ISSUE = 2'd1, ST_HAZARD = 2'd2} state_e;

  state_e                state_q, state_d;
  logic                  ex_valid_q, ex_valid_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, imm_q, imm_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [REG_AW-1:0]     rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
  logic                  rd_we_q, rd_we_d, src_a_sel_q, src_a_sel_d, src_b_sel_q, src_b_sel_d;
  logic [3:0]            alu_op_q, alu_op_d;

  logic                  xfer_in, hazard_in, hazard_held;
  logic                  id_rs1_hit, id_rs2_hit, rs1_stall, rs2_stall;
  logic                  wb_rs1_in, wb_rs2_in, wb_rs1_held, wb_rs2_held;
  logic [DATA_WIDTH-1:0] rs1_fwd, rs2_fwd;

  assign id_ready_o = (state_q == ST_EMPTY) || ((state_q == ST_ISSUE) && ex_ready_i);
  assign xfer_in    = id_valid_i && id_ready_o;

  assign id_rs1_hit = mem_rd_we_i && (id_rs1_addr_i != '0) && (id_rs1_addr_i == mem_rd_addr_i);
  assign id_rs2_hit = mem_rd_we_i && (id_rs2_addr_i != '0) && (id_rs2_addr_i == mem_rd_addr_i);
`ifdef ADMO_FWD_EN
  assign hazard_in = mem_is_load_i &&
                     (((id_src_a_sel_i == SRC_A_RS1) && id_rs1_hit) || id_rs2_hit);
`else
  assign hazard_in = ((id_src_a_sel_i == SRC_A_RS1) && id_rs1_hit) || id_rs2_hit;
`endif
  // rs2 always counts: even with an immediate it feeds the store-data port.
  assign hazard_held = ((src_a_sel_q == SRC_A_RS1) && rs1_stall) || rs2_stall;

  assign wb_rs1_in   = wb_rd_we_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == id_rs1_addr_i);
  assign wb_rs2_in   = wb_rd_we_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == id_rs2_addr_i);
  assign wb_rs1_held = wb_rd_we_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == rs1_addr_q);
  assign wb_rs2_held = wb_rd_we_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == rs2_addr_q);

  admo_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_fwd_rs1 (
    .src_addr_i(rs1_addr_q), .held_data_i(rs1_data_q),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_we_i(mem_rd_we_i),
    .mem_is_load_i(mem_is_load_i), .mem_rd_data_i(mem_rd_data_i),
    .data_o(rs1_fwd), .stall_o(rs1_stall)
  );

  admo_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_AW(REG_AW)) u_fwd_rs2 (
    .src_addr_i(rs2_addr_q), .held_data_i(rs2_data_q),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_we_i(mem_rd_we_i),
    .mem_is_load_i(mem_is_load_i), .mem_rd_data_i(mem_rd_data_i),
    .data_o(rs2_fwd), .stall_o(rs2_stall)
  );

  always_comb begin
    pc_d        = pc_q;
    imm_d       = imm_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    rd_we_d     = rd_we_q;
    alu_op_d    = alu_op_q;
    src_a_sel_d = src_a_sel_q;
    src_b_sel_d = src_b_sel_q;
    state_d     = state_q;

    if (state_q != ST_EMPTY) begin
      if (wb_rs1_held) rs1_data_d = wb_rd_data_i;
      if (wb_rs2_held) rs2_data_d = wb_rd_data_i;
    end

    if (xfer_in && !flush_i) begin
      pc_d        = id_pc_i;
      imm_d       = id_imm_i;
      rs1_data_d  = wb_rs1_in ? wb_rd_data_i : id_rs1_data_i;
      rs2_data_d  = wb_rs2_in ? wb_rd_data_i : id_rs2_data_i;
      rs1_addr_d  = id_rs1_addr_i;
      rs2_addr_d  = id_rs2_addr_i;
      rd_addr_d   = id_rd_addr_i;
      rd_we_d     = id_rd_we_i;
      alu_op_d    = id_alu_op_i;
      src_a_sel_d = id_src_a_sel_i;
      src_b_sel_d = id_src_b_sel_i;
    end

    if (flush_i)                                        state_d = ST_EMPTY;
    else if (xfer_in)                                   state_d = hazard_in ? ST_HAZARD : ST_ISSUE;
    else if (ex_valid_q && ex_ready_i)                  state_d = ST_EMPTY;
    else if ((state_q == ST_HAZARD) && !hazard_held)    state_d = ST_ISSUE;

    ex_valid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_EMPTY;
      ex_valid_q  <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rd_we_q     <= 1'b0;
      alu_op_q    <= '0;
      src_a_sel_q <= 1'b0;
      src_b_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ex_valid_q  <= ex_valid_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_we_q     <= rd_we_d;
      alu_op_q    <= alu_op_d;
      src_a_sel_q <= src_a_sel_d;
      src_b_sel_q <= src_b_sel_d;
    end
  end

  assign ex_valid_o      = ex_valid_q;
  assign ex_operand_a_o  = (src_a_sel_q == SRC_A_PC)  ? pc_q  : rs1_fwd;
  assign ex_operand_b_o  = (src_b_sel_q == SRC_B_IMM) ? imm_q : rs2_fwd;
  assign ex_store_data_o = rs2_fwd;
  assign ex_alu_op_o     = alu_op_q;
  assign ex_rd_addr_o    = rd_addr_q;
  assign ex_rd_we_o      = rd_we_q;

endmodule

// File: tb/tb_admo_issue_stage.sv
// tb/tb_admo_issue_stage.sv - bench for admo_issue_stage (honours ADMO_FWD_EN)
module tb_admo_issue_stage;
  import admo_issue_stage_pkg::*;

  logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i, id_valid_i, id_ready_o;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic        id_rd_we_i, id_src_a_sel_i, id_src_b_sel_i;
  logic [3:0]  id_alu_op_i;
  logic [4:0]  mem_rd_addr_i, wb_rd_addr_i;
  logic        mem_rd_we_i, mem_is_load_i, wb_rd_we_i;
  logic [31:0] mem_rd_data_i, wb_rd_data_i;
  logic        ex_valid_o, ex_ready_i, ex_rd_we_o;
  logic [31:0] ex_operand_a_o, ex_operand_b_o, ex_store_data_o;
  logic [3:0]  ex_alu_op_o;
  logic [4:0]  ex_rd_addr_o;

  always #5 clk_i = ~clk_i;

  admo_issue_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rd_addr_i(id_rd_addr_i), .id_rd_we_i(id_rd_we_i), .id_alu_op_i(id_alu_op_i),
    .id_src_a_sel_i(id_src_a_sel_i), .id_src_b_sel_i(id_src_b_sel_i),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_we_i(mem_rd_we_i),
    .mem_rd_data_i(mem_rd_data_i), .mem_is_load_i(mem_is_load_i),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_we_i(wb_rd_we_i), .wb_rd_data_i(wb_rd_data_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_operand_a_o(ex_operand_a_o), .ex_operand_b_o(ex_operand_b_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_we_o(ex_rd_we_o),
    .ex_store_data_o(ex_store_data_o)
  );

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; id_valid_i = 0; id_pc_i = 0; id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rd_addr_i = 0; id_rd_we_i = 0; id_alu_op_i = 0;
    id_src_a_sel_i = 0; id_src_b_sel_i = 0;
    mem_rd_addr_i = 0; mem_rd_we_i = 0; mem_rd_data_i = 0; mem_is_load_i = 0;
    wb_rd_addr_i = 0; wb_rd_we_i = 0; wb_rd_data_i = 0; ex_ready_i = 0;
  endtask

  task automatic drive_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] pc, input logic [31:0] imm,
                          input logic sa, input logic sb, input logic [3:0] op,
                          input logic [4:0] rd, input logic we);
    id_valid_i = 1; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rs1_data_i = d1; id_rs2_data_i = d2;
    id_pc_i = pc; id_imm_i = imm; id_src_a_sel_i = sa; id_src_b_sel_i = sb; id_alu_op_i = op;
    id_rd_addr_i = rd; id_rd_we_i = we;
  endtask

  // Behavioural reference: a held instruction (or none) and whether it is waiting on a load.
  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, pc, imm;
    logic        sa, sb, we;
    logic [3:0]  op;
  } instr_t;

  instr_t m_slot;
  bit     m_full = 0, m_blocked = 0;

  function automatic bit m_hit(input logic [4:0] a);
    return mem_rd_we_i && (a != 0) && (a == mem_rd_addr_i);
  endfunction

  function automatic bit m_stall(input logic [4:0] a);
`ifdef ADMO_FWD_EN
    return m_hit(a) && mem_is_load_i;
`else
    return m_hit(a);
`endif
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] d);
`ifdef ADMO_FWD_EN
    if (m_hit(a) && !mem_is_load_i) return mem_rd_data_i;
`endif
    return d;
  endfunction

  function automatic bit m_wb(input logic [4:0] a);
    return wb_rd_we_i && (a != 0) && (a == wb_rd_addr_i);
  endfunction

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, pc, imm;
    logic        sa, sb;
    logic [3:0]  op;
    logic [4:0]  mrd;
    logic        mwe, mld;
    logic [31:0] mdata, ea_f, eb_f, es_f, ea_n, eb_n, es_n;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit          ev, er;
    logic [31:0] ea, eb, es;

    vecs[0] = '{5'd1, 5'd2, 32'h10, 32'h20, 32'h0,   32'h0,  1'b0, 1'b0, ALU_SUB, 5'd0, 1'b0, 1'b0, 32'h0,
                32'h10,  32'h20, 32'h20, 32'h10,  32'h20, 32'h20};
    vecs[1] = '{5'd1, 5'd2, 32'h10, 32'h20, 32'h100, 32'h8,  1'b1, 1'b1, ALU_OR,  5'd2, 1'b0, 1'b0, 32'h99,
                32'h100, 32'h8,  32'h20, 32'h100, 32'h8,  32'h20};
    vecs[2] = '{5'd4, 5'd6, 32'h5,  32'h7,  32'h0,   32'h0,  1'b0, 1'b0, ALU_AND, 5'd4, 1'b1, 1'b0, 32'hAA,
                32'hAA,  32'h7,  32'h7,  32'h5,   32'h7,  32'h7};
    vecs[3] = '{5'd4, 5'd6, 32'h5,  32'h7,  32'h0,   32'h30, 1'b0, 1'b1, ALU_XOR, 5'd6, 1'b1, 1'b0, 32'hBB,
                32'h5,   32'h30, 32'hBB, 32'h5,   32'h30, 32'h7};
    vecs[4] = '{5'd4, 5'd6, 32'h5,  32'h7,  32'h0,   32'h0,  1'b0, 1'b0, ALU_SLT, 5'd4, 1'b0, 1'b0, 32'hCC,
                32'h5,   32'h7,  32'h7,  32'h5,   32'h7,  32'h7};
    vecs[5] = '{5'd0, 5'd6, 32'h0,  32'h7,  32'h0,   32'h0,  1'b0, 1'b0, ALU_ADD, 5'd0, 1'b1, 1'b0, 32'hEE,
                32'h0,   32'h7,  32'h7,  32'h0,   32'h7,  32'h7};
    vecs[6] = '{5'd4, 5'd6, 32'h5,  32'h7,  32'h200, 32'h0,  1'b1, 1'b0, ALU_SRA, 5'd4, 1'b1, 1'b0, 32'hDD,
                32'h200, 32'h7,  32'h7,  32'h200, 32'h7,  32'h7};

    idle();
    repeat (2) @(negedge clk_i);
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_id_ready", id_ready_o, 1);
    chk("rst_opa", ex_operand_a_o, 0);
    chk("rst_opb", ex_operand_b_o, 0);
    chk("rst_op", ex_alu_op_o, 0);
    chk("rst_rd", {ex_rd_we_o, ex_rd_addr_o}, 0);
    chk("rst_store", ex_store_data_o, 0);
    rst_ni = 1;
    tick();

    // Back-to-back ADD / SUB at full throughput
    drive_id(5, 7, 3, 4, 0, 0, 0, 0, ALU_ADD, 1, 1); ex_ready_i = 1;
    tick();
    drive_id(5, 7, 8, 9, 0, 0, 0, 0, ALU_SUB, 2, 1);
    @(negedge clk_i);
    chk("b2b_valid1", ex_valid_o, 1); chk("b2b_a1", ex_operand_a_o, 3);
    chk("b2b_b1", ex_operand_b_o, 4); chk("b2b_op1", ex_alu_op_o, ALU_ADD);
    chk("b2b_ready", id_ready_o, 1);
    tick();
    idle(); ex_ready_i = 1;
    @(negedge clk_i);
    chk("b2b_valid2", ex_valid_o, 1); chk("b2b_a2", ex_operand_a_o, 8);
    chk("b2b_b2", ex_operand_b_o, 9); chk("b2b_op2", ex_alu_op_o, ALU_SUB);
    tick();
    @(negedge clk_i);
    chk("b2b_drain", ex_valid_o, 0);
    tick();

    // MEM non-load writes x3 while x3 is a source
    idle(); drive_id(3, 0, 32'h55, 0, 0, 0, 0, 0, ALU_ADD, 1, 1);
    mem_rd_addr_i = 3; mem_rd_we_i = 1; mem_rd_data_i = 32'h1234; ex_ready_i = 1;
    tick();
    id_valid_i = 0;
`ifdef ADMO_FWD_EN
    @(negedge clk_i);
    chk("fwd_valid", ex_valid_o, 1); chk("fwd_a", ex_operand_a_o, 32'h1234);
    tick();
`else
    mem_rd_we_i = 0; wb_rd_addr_i = 3; wb_rd_we_i = 1; wb_rd_data_i = 32'h1234;
    @(negedge clk_i);
    chk("nofwd_stall", ex_valid_o, 0);
    tick();
    idle(); ex_ready_i = 1;
    @(negedge clk_i);
    chk("nofwd_valid", ex_valid_o, 1); chk("nofwd_a", ex_operand_a_o, 32'h1234);
    tick();
`endif

    // Load-use on rs2 resolved by WB snoop
    idle(); drive_id(0, 3, 0, 32'h77, 0, 0, 0, 0, ALU_ADD, 1, 1);
    mem_rd_addr_i = 3; mem_rd_we_i = 1; mem_is_load_i = 1; ex_ready_i = 1;
    tick();
    idle(); ex_ready_i = 1; wb_rd_addr_i = 3; wb_rd_we_i = 1; wb_rd_data_i = 32'hBEEF;
    @(negedge clk_i);
    chk("load_stall", ex_valid_o, 0);
    tick();
    idle(); ex_ready_i = 1;
    @(negedge clk_i);
    chk("load_valid", ex_valid_o, 1); chk("load_b", ex_operand_b_o, 32'hBEEF);
    chk("load_store", ex_store_data_o, 32'hBEEF);
    tick();

    // Backpressure for three cycles
    idle(); drive_id(1, 2, 32'h11, 32'h22, 0, 0, 0, 0, ALU_ADD, 4, 1); ex_ready_i = 1;
    tick();
    drive_id(1, 2, 32'h33, 32'h44, 0, 0, 0, 0, ALU_SUB, 5, 1); ex_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("bp_valid", ex_valid_o, 1); chk("bp_a", ex_operand_a_o, 32'h11);
      chk("bp_b", ex_operand_b_o, 32'h22); chk("bp_rd", ex_rd_addr_o, 4);
      chk("bp_id_ready", id_ready_o, 0);
      tick();
    end
    ex_ready_i = 1;
    @(negedge clk_i);
    chk("bp_release_a", ex_operand_a_o, 32'h11); chk("bp_release_ready", id_ready_o, 1);
    tick();
    idle(); ex_ready_i = 1;
    @(negedge clk_i);
    chk("bp_next_valid", ex_valid_o, 1); chk("bp_next_a", ex_operand_a_o, 32'h33);
    chk("bp_next_op", ex_alu_op_o, ALU_SUB);
    tick();
    @(negedge clk_i);
    chk("bp_no_dup", ex_valid_o, 0);
    tick();

    // Flush concurrent with an incoming instruction
    idle(); drive_id(1, 2, 1, 2, 0, 0, 0, 0, ALU_ADD, 1, 1); flush_i = 1; ex_ready_i = 1;
    tick();
    idle(); ex_ready_i = 1;
    @(negedge clk_i);
    chk("flush_valid", ex_valid_o, 0); chk("flush_ready", id_ready_o, 1);
    tick();
    @(negedge clk_i);
    chk("flush_dropped", ex_valid_o, 0);

    // x0 is never forwarded or stalled on
    idle(); drive_id(0, 2, 0, 5, 0, 0, 0, 0, ALU_ADD, 1, 1);
    mem_rd_addr_i = 0; mem_rd_we_i = 1; mem_rd_data_i = 32'hFFFF;
    tick();
    id_valid_i = 0; ex_ready_i = 1;
    @(negedge clk_i);
    chk("x0_valid", ex_valid_o, 1); chk("x0_a", ex_operand_a_o, 0);
    tick();

    for (int v = 0; v < 7; v++) begin
      idle();
      drive_id(vecs[v].rs1, vecs[v].rs2, vecs[v].d1, vecs[v].d2, vecs[v].pc, vecs[v].imm,
               vecs[v].sa, vecs[v].sb, vecs[v].op, 5'd9, 1'b1);
      tick();
      id_valid_i = 0;
      mem_rd_addr_i = vecs[v].mrd; mem_rd_we_i = vecs[v].mwe;
      mem_is_load_i = vecs[v].mld; mem_rd_data_i = vecs[v].mdata;
`ifdef ADMO_FWD_EN
      ea = vecs[v].ea_f; eb = vecs[v].eb_f; es = vecs[v].es_f;
`else
      ea = vecs[v].ea_n; eb = vecs[v].eb_n; es = vecs[v].es_n;
`endif
      @(negedge clk_i);
      chk($sformatf("vec%0d_valid", v), ex_valid_o, 1);
      chk($sformatf("vec%0d_a", v), ex_operand_a_o, ea);
      chk($sformatf("vec%0d_b", v), ex_operand_b_o, eb);
      chk($sformatf("vec%0d_store", v), ex_store_data_o, es);
      chk($sformatf("vec%0d_op", v), ex_alu_op_o, vecs[v].op);
      ex_ready_i = 1;
      tick();
    end

    idle();
    m_full = 0; m_blocked = 0;
    for (int c = 0; c < 400; c++) begin
      id_valid_i     = ($urandom_range(0, 9) < 7);
      id_rs1_addr_i  = 5'($urandom_range(0, 3));
      id_rs2_addr_i  = 5'($urandom_range(0, 3));
      id_rd_addr_i   = 5'($urandom_range(0, 31));
      id_rd_we_i     = 1'($urandom_range(0, 1));
      id_rs1_data_i  = $urandom; id_rs2_data_i = $urandom;
      id_pc_i        = $urandom; id_imm_i      = $urandom;
      id_src_a_sel_i = 1'($urandom_range(0, 1));
      id_src_b_sel_i = 1'($urandom_range(0, 1));
      id_alu_op_i    = 4'($urandom_range(0, 9));
      mem_rd_addr_i  = 5'($urandom_range(0, 3));
      mem_rd_we_i    = 1'($urandom_range(0, 1));
      mem_is_load_i  = 1'($urandom_range(0, 1));
      mem_rd_data_i  = $urandom;
      wb_rd_addr_i   = 5'($urandom_range(0, 3));
      wb_rd_we_i     = 1'($urandom_range(0, 1));
      wb_rd_data_i   = $urandom;
      ex_ready_i     = ($urandom_range(0, 9) < 7);
      flush_i        = ($urandom_range(0, 19) == 0);
      @(negedge clk_i);
      ev = m_full && !m_blocked;
      er = !m_full || (!m_blocked && ex_ready_i);
      chk("rnd_valid", ex_valid_o, ev);
      chk("rnd_id_ready", id_ready_o, er);
      if (ev) begin
        chk("rnd_a", ex_operand_a_o, m_slot.sa ? m_slot.pc : m_fwd(m_slot.rs1, m_slot.d1));
        chk("rnd_b", ex_operand_b_o, m_slot.sb ? m_slot.imm : m_fwd(m_slot.rs2, m_slot.d2));
        chk("rnd_store", ex_store_data_o, m_fwd(m_slot.rs2, m_slot.d2));
        chk("rnd_op", ex_alu_op_o, m_slot.op);
        chk("rnd_rd", {ex_rd_we_o, ex_rd_addr_o}, {m_slot.we, m_slot.rd});
      end
      @(posedge clk_i);
      if (m_full) begin
        if (m_wb(m_slot.rs1)) m_slot.d1 = wb_rd_data_i;
        if (m_wb(m_slot.rs2)) m_slot.d2 = wb_rd_data_i;
      end
      if (flush_i) m_full = 0;
      else if (id_valid_i && er) begin
        m_slot = '{rs1: id_rs1_addr_i, rs2: id_rs2_addr_i, rd: id_rd_addr_i,
                   d1: m_wb(id_rs1_addr_i) ? wb_rd_data_i : id_rs1_data_i,
                   d2: m_wb(id_rs2_addr_i) ? wb_rd_data_i : id_rs2_data_i,
                   pc: id_pc_i, imm: id_imm_i, sa: id_src_a_sel_i, sb: id_src_b_sel_i,
                   we: id_rd_we_i, op: id_alu_op_i};
        m_full    = 1;
        m_blocked = (!id_src_a_sel_i && m_stall(id_rs1_addr_i)) || m_stall(id_rs2_addr_i);
      end else if (ev && ex_ready_i) m_full = 0;
      else if (m_full && m_blocked &&
               !((!m_slot.sa && m_stall(m_slot.rs1)) || m_stall(m_slot.rs2))) m_blocked = 0;
      #1;
    end

    // Asynchronous reset while stalled on a load
    idle(); flush_i = 1; tick();
    idle(); drive_id(0, 3, 0, 32'h77, 0, 0, 0, 0, ALU_SUB, 1, 1);
    mem_rd_addr_i = 3; mem_rd_we_i = 1; mem_is_load_i = 1; ex_ready_i = 1;
    tick();
    id_valid_i = 0;
    @(negedge clk_i);
    chk("rsthz_stalled", ex_valid_o, 0);
    #2 rst_ni = 0;
    #1;
    chk("rsthz_valid", ex_valid_o, 0); chk("rsthz_ready", id_ready_o, 1);
    chk("rsthz_op", ex_alu_op_o, 0); chk("rsthz_b", ex_operand_b_o, 0);
    @(negedge clk_i);
    rst_ni = 1;
    idle(); ex_ready_i = 1;
    tick();
    @(negedge clk_i);
    chk("rsthz_after", ex_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
